// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 device-side responder: command fields,
// FSM state encoding and the key-word packing used on key-read commands.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int READ  = 1;
  localparam int FIXED = 2;

  localparam int ram_depth = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  // Byte n of the key word carries key n in bit0 and key n+4 in bit4.
  function automatic logic [31:0] pack_keys(input logic [7:0] k);
    return {3'b000, k[7], 3'b000, k[3],
            3'b000, k[6], 3'b000, k[2],
            3'b000, k[5], 3'b000, k[1],
            3'b000, k[4], 3'b000, k[0]};
  endfunction

endpackage

// File: rtl/tm1638_input_sync.sv
// Brings the host's STB/CLK/DIO into the clk domain and produces registered
// edge pulses for CLK and STB, aligned with a matching delayed DIO level.
module tm1638_input_sync #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tm_stb,
  input  logic i_tm_clk,
  input  logic i_tm_dio,
  output logic o_stb,
  output logic o_dio,
  output logic o_clk_rise,
  output logic o_clk_fall,
  output logic o_stb_rise,
  output logic o_stb_fall
);

  logic [sync_stages-1:0] r_stb_sync;
  logic [sync_stages-1:0] r_clk_sync;
  logic [sync_stages-1:0] r_dio_sync;
  logic                   r_stb_prev;
  logic                   r_clk_prev;
  logic                   r_dio_d;
  logic                   r_clk_rise;
  logic                   r_clk_fall;
  logic                   r_stb_rise;
  logic                   r_stb_fall;

  logic w_stb;
  logic w_clk;
  logic w_dio;

  assign w_stb = r_stb_sync[sync_stages-1];
  assign w_clk = r_clk_sync[sync_stages-1];
  assign w_dio = r_dio_sync[sync_stages-1];

  // STB and CLK idle high on the bus, so they reset high to avoid a
  // phantom edge straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stb_sync <= '1;
      r_clk_sync <= '1;
      r_dio_sync <= '0;
      r_stb_prev <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dio_d    <= 1'b0;
      r_clk_rise <= 1'b0;
      r_clk_fall <= 1'b0;
      r_stb_rise <= 1'b0;
      r_stb_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every flop the pre-edge value of
      // its neighbour, which is exactly what a synchronizer chain needs.
      r_stb_sync <= (r_stb_sync << 1) | sync_stages'(i_tm_stb);
      r_clk_sync <= (r_clk_sync << 1) | sync_stages'(i_tm_clk);
      r_dio_sync <= (r_dio_sync << 1) | sync_stages'(i_tm_dio);
      r_stb_prev <= w_stb;
      r_clk_prev <= w_clk;
      r_dio_d    <= w_dio;
      r_clk_rise <= w_clk & ~r_clk_prev;
      r_clk_fall <= ~w_clk & r_clk_prev;
      r_stb_rise <= w_stb & ~r_stb_prev;
      r_stb_fall <= ~w_stb & r_stb_prev;
    end
  end

  assign o_stb      = w_stb;
  assign o_dio      = r_dio_d;
  assign o_clk_rise = r_clk_rise;
  assign o_clk_fall = r_clk_fall;
  assign o_stb_rise = r_stb_rise;
  assign o_stb_fall = r_stb_fall;

endmodule

// File: rtl/tm1638_serial_responder.sv
// TM1638 device emulation: decodes host commands, holds the 16-byte display
// RAM, drives digit/LED/display-control outputs and returns key state.
module tm1638_serial_responder
  import tm1638_pkg::*;
#(
  parameter int w_digit     = 8,
  parameter int w_keys      = 8,
  parameter int sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tm_stb,
  input  logic                 tm_clk,
  input  logic                 tm_dio_in,
  output logic                 tm_dio_out,
  output logic                 tm_dio_oe,
  input  logic [w_keys-1:0]    keys,
  output logic [w_digit*8-1:0] hex,
  output logic [w_digit-1:0]   led,
  output logic                 display_on,
  output logic [2:0]           brightness,
  output logic                 write_strobe
);

  logic w_stb_lvl;
  logic w_dio;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_stb_rise;
  logic w_stb_fall;

  tm1638_input_sync #(.sync_stages(sync_stages)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_tm_stb   (tm_stb),
    .i_tm_clk   (tm_clk),
    .i_tm_dio   (tm_dio_in),
    .o_stb      (w_stb_lvl),
    .o_dio      (w_dio),
    .o_clk_rise (w_clk_rise),
    .o_clk_fall (w_clk_fall),
    .o_stb_rise (w_stb_rise),
    .o_stb_fall (w_stb_fall)
  );

  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [3:0]       r_addr;
  logic             r_fixed;
  logic [31:0]      r_key_word;
  logic [5:0]       r_rd_idx;
  logic [7:0]       r_ram [ram_depth];
  logic             r_dio_out;
  logic             r_dio_oe;
  logic             r_disp_on;
  logic [2:0]       r_bright;
  logic             r_wstb;
  logic [w_digit*8-1:0] r_hex;
  logic [w_digit-1:0]   r_led;

  logic [7:0]           w_keys8;
  logic [31:0]          w_key_word;
  logic [7:0]           w_byte;
  logic                 w_rise;
  logic [w_digit*8-1:0] w_hex_next;
  logic [w_digit-1:0]   w_led_next;

  // NOTE: always_comb assigns a default before the partial overwrite so no
  // path leaves w_keys8 unassigned and no latch is inferred.
  always_comb begin
    w_keys8              = '0;
    w_keys8[w_keys-1:0]  = keys;
  end

  assign w_key_word = pack_keys(w_keys8);
  assign w_byte     = {w_dio, r_shift[7:1]};
  // Host clock rises only count while the strobe is still held low.
  assign w_rise     = w_clk_rise & ~w_stb_lvl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_fixed    <= 1'b0;
      r_key_word <= '0;
      r_rd_idx   <= '0;
      // NOTE: the display RAM is reset because the outputs mirror it every
      // cycle; a stale RAM would reappear on hex/led right after reset.
      r_ram      <= '{default: '0};
      r_dio_out  <= 1'b0;
      r_dio_oe   <= 1'b0;
      r_disp_on  <= 1'b0;
      r_bright   <= '0;
      r_wstb     <= 1'b0;
    end else begin
      r_wstb <= 1'b0;
      if (w_stb_rise) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_dio_oe  <= 1'b0;
        r_dio_out <= 1'b0;
      end else if (w_stb_fall) begin
        // A clock rise coinciding with the strobe fall becomes bit 0.
        r_state   <= CMD;
        r_bit_cnt <= w_rise ? 3'd1 : 3'd0;
        if (w_rise)
          r_shift <= w_byte;
      end else begin
        case (r_state)
          CMD, WDATA: begin
            if (w_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == CMD) begin
                  case (w_byte[7:6])
                    CMD_DATA: begin
                      r_fixed <= w_byte[FIXED];
                      if (w_byte[READ]) begin
                        r_key_word <= w_key_word;
                        r_rd_idx   <= '0;
                        r_state    <= RDATA;
                      end else begin
                        r_state <= IGNORE;
                      end
                    end
                    CMD_DISP: begin
                      r_disp_on <= w_byte[3];
                      r_bright  <= w_byte[2:0];
                      r_state   <= IGNORE;
                    end
                    CMD_ADDR: begin
                      r_addr  <= w_byte[3:0];
                      r_state <= WDATA;
                    end
                    default: r_state <= IGNORE;
                  endcase
                end else begin
                  r_ram[r_addr] <= w_byte;
                  r_wstb        <= 1'b1;
                  if (!r_fixed)
                    r_addr <= r_addr + 4'd1;
                end
              end
            end
          end
          RDATA: begin
            if (w_clk_fall) begin
              r_dio_oe <= 1'b1;
              if (r_rd_idx[5]) begin
                r_dio_out <= 1'b0;
              end else begin
                r_dio_out <= r_key_word[r_rd_idx[4:0]];
                r_rd_idx  <= r_rd_idx + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < w_digit; k++) begin : g_digit
    assign w_hex_next[8*k +: 8] = r_ram[2*k];
    assign w_led_next[k]        = r_ram[2*k+1][0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hex <= '0;
      r_led <= '0;
    end else begin
      r_hex <= w_hex_next;
      r_led <= w_led_next;
    end
  end

  assign tm_dio_out   = r_dio_out;
  assign tm_dio_oe    = r_dio_oe;
  assign hex          = r_hex;
  assign led          = r_led;
  assign display_on   = r_disp_on;
  assign brightness   = r_bright;
  assign write_strobe = r_wstb;

endmodule

// File: tb/tb_tm1638_serial_responder.sv
// Directed bench for the TM1638 responder: drives the host side of the
// 3-wire bus and compares outputs against hand-computed values.
module tb_tm1638_serial_responder;

  localparam int HALF = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tm_stb = 1'b1;
  logic        tm_clk = 1'b1;
  logic        tm_dio_in = 1'b1;
  logic [7:0]  keys = '0;
  logic        tm_dio_out;
  logic        tm_dio_oe;
  logic [63:0] hex;
  logic [7:0]  led;
  logic        display_on;
  logic [2:0]  brightness;
  logic        write_strobe;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_strobes = 0;

  tm1638_serial_responder #(
    .w_digit     (8),
    .w_keys      (8),
    .sync_stages (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tm_stb       (tm_stb),
    .tm_clk       (tm_clk),
    .tm_dio_in    (tm_dio_in),
    .tm_dio_out   (tm_dio_out),
    .tm_dio_oe    (tm_dio_oe),
    .keys         (keys),
    .hex          (hex),
    .led          (led),
    .display_on   (display_on),
    .brightness   (brightness),
    .write_strobe (write_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (write_strobe === 1'b1) n_strobes++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stb_low();
    tm_stb = 1'b0;
    #(2*HALF);
  endtask

  task automatic stb_high();
    tm_clk = 1'b1;
    tm_stb = 1'b1;
    #(2*HALF);
  endtask

  task automatic host_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk    = 1'b0;
      tm_dio_in = b[i];
      #HALF;
      tm_clk = 1'b1;
      #HALF;
    end
  endtask

  task automatic host_byte(input logic [7:0] b);
    host_bits(b, 8);
  endtask

  task automatic host_read_byte(output logic [7:0] b);
    b = '0;
    tm_dio_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tm_clk = 1'b0;
      #HALF;
      b[i]   = tm_dio_out;
      tm_clk = 1'b1;
      #HALF;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    stb_low();
    host_byte(b);
    stb_high();
  endtask

  initial begin
    logic [7:0] pat [4];
    logic [7:0] rb;
    logic [7:0] exp_key0 [4];
    int         s0;

    pat      = '{8'h3F, 8'h01, 8'h06, 8'h00};
    exp_key0 = '{8'h01, 8'h10, 8'h00, 8'h00};

    #40;
    check("rst_hex",    hex,          64'h0);
    check("rst_led",    led,          8'h00);
    check("rst_disp",   display_on,   1'b0);
    check("rst_bright", brightness,   3'd0);
    check("rst_oe",     tm_dio_oe,    1'b0);
    check("rst_dout",   tm_dio_out,   1'b0);
    check("rst_wstb",   write_strobe, 1'b0);
    rst = 1'b1;
    #100;

    // Auto-increment write of all 16 RAM bytes.
    send_cmd(8'h40);
    s0 = n_strobes;
    stb_low();
    host_byte(8'hC0);
    for (int i = 0; i < 16; i++) host_byte(pat[i%4]);
    stb_high();
    check("auto_strobes", 64'(n_strobes - s0), 64'd16);
    check("auto_hex0",    hex[7:0],  8'h3F);
    check("auto_led0",    led[0],    1'b1);
    check("auto_hex1",    hex[15:8], 8'h06);
    check("auto_led1",    led[1],    1'b0);
    check("auto_hex_all", hex,       64'h063F063F063F063F);
    check("auto_led_all", led,       8'h55);

    // Fixed-address write: two bytes to address 5 only.
    send_cmd(8'h44);
    s0 = n_strobes;
    stb_low();
    host_byte(8'hC5);
    host_byte(8'h01);
    host_byte(8'h00);
    stb_high();
    check("fixed_strobes", 64'(n_strobes - s0), 64'd2);
    check("fixed_led2",    led[2],     1'b0);
    check("fixed_hex2",    hex[23:16], 8'h3F);
    check("fixed_hex3",    hex[31:24], 8'h06);
    check("fixed_led_all", led,        8'h51);

    // Display control.
    send_cmd(8'h8A);
    check("disp_on_a",  display_on, 1'b1);
    check("disp_br_a",  brightness, 3'd2);
    send_cmd(8'h8B);
    check("disp_on_b",  display_on, 1'b1);
    check("disp_br_b",  brightness, 3'd3);
    check("disp_hex",   hex,        64'h063F063F063F063F);
    check("disp_led",   led,        8'h51);

    // Key read, two key patterns.
    keys = 8'b0010_0001;
    stb_low();
    host_byte(8'h42);
    for (int n = 0; n < 4; n++) begin
      host_read_byte(rb);
      check($sformatf("key_a_byte%0d", n), rb, exp_key0[n]);
    end
    check("key_oe_on", tm_dio_oe, 1'b1);
    tm_clk = 1'b0;
    #HALF;
    check("key_tail_dout", tm_dio_out, 1'b0);
    check("key_tail_oe",   tm_dio_oe,  1'b1);
    stb_high();
    check("key_oe_off", tm_dio_oe, 1'b0);

    keys = 8'hFF;
    stb_low();
    host_byte(8'h42);
    for (int n = 0; n < 4; n++) begin
      host_read_byte(rb);
      check($sformatf("key_b_byte%0d", n), rb, 8'h11);
    end
    stb_high();

    // Abort a data byte after 5 bits.
    s0 = n_strobes;
    stb_low();
    host_byte(8'hC2);
    host_bits(8'hFF, 5);
    stb_high();
    check("abort_strobes", 64'(n_strobes - s0), 64'd0);
    check("abort_hex1",    hex[15:8], 8'h06);

    // Address wrap 15 -> 0 in auto mode.
    send_cmd(8'h40);
    stb_low();
    host_byte(8'hCF);
    host_byte(8'h01);
    stb_high();
    check("wrap_pre_led7", led[7], 1'b1);
    s0 = n_strobes;
    stb_low();
    host_byte(8'hCF);
    host_byte(8'hAA);
    host_byte(8'hBB);
    stb_high();
    check("wrap_strobes", 64'(n_strobes - s0), 64'd2);
    check("wrap_led7",    led[7],   1'b0);
    check("wrap_hex0",    hex[7:0], 8'hBB);

    // Reset in the middle of a key read.
    keys = 8'h01;
    stb_low();
    host_byte(8'h42);
    host_read_byte(rb);
    check("mid_read_byte", rb, 8'h01);
    check("mid_read_oe",   tm_dio_oe, 1'b1);
    rst = 1'b0;
    #10;
    check("mrst_oe",     tm_dio_oe,  1'b0);
    check("mrst_dout",   tm_dio_out, 1'b0);
    check("mrst_hex",    hex,        64'h0);
    check("mrst_led",    led,        8'h00);
    check("mrst_disp",   display_on, 1'b0);
    check("mrst_bright", brightness, 3'd0);
    rst = 1'b1;
    #100;
    stb_high();
    s0 = n_strobes;
    stb_low();
    host_byte(8'hC0);
    host_byte(8'h5B);
    host_byte(8'h01);
    stb_high();
    check("post_strobes", 64'(n_strobes - s0), 64'd2);
    check("post_hex0",    hex[7:0], 8'h5B);
    check("post_led0",    led[0],   1'b1);
    check("post_oe",      tm_dio_oe, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
